// File: rtl/seq_game_engine.sv
// Note-sequence memory game engine: loads a note sequence, plays a growing prefix with tick timing,
// then scores the player's answers with per-answer timeout, miss counting, win detection and abort.
module seq_game_engine #(
  parameter int NOTE_W        = 4,
  parameter int DEPTH         = 8,
  parameter int START_LEN     = 3,
  parameter int TICK_DIV      = 5000000,
  parameter int NOTE_TICKS    = 3,
  parameter int GAP_TICKS     = 1,
  parameter int MISS_TICKS    = 2,
  parameter int TIMEOUT_TICKS = 10,
  parameter int MISS_W        = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [NOTE_W*DEPTH-1:0]      load_data,
  input  logic                         answer_valid,
  input  logic [NOTE_W-1:0]            answer,
  input  logic                         abort,
  output logic [NOTE_W-1:0]            note_out,
  output logic                         note_active,
  output logic [NOTE_W-1:0]            led_out,
  output logic [2:0]                   state_out,
  output logic [$clog2(DEPTH+1)-1:0]   level_out,
  output logic [MISS_W-1:0]            miss_count,
  output logic                         miss_pulse,
  output logic                         level_pulse,
  output logic                         win_pulse
);

  localparam int LW    = $clog2(DEPTH + 1);
  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MT_A  = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int MT_B  = (MISS_TICKS > TIMEOUT_TICKS) ? MISS_TICKS : TIMEOUT_TICKS;
  localparam int MAX_T = (MT_A > MT_B) ? MT_A : MT_B;
  localparam int TW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PLAY_ON  = 3'd1,
    PLAY_GAP = 3'd2,
    LISTEN   = 3'd3,
    MISS     = 3'd4,
    WIN      = 3'd5
  } state_t;

  state_t                    state, state_n;
  logic [NOTE_W*DEPTH-1:0]   seq, seq_n;
  logic [LW-1:0]             idx, idx_n, len, len_n;
  logic [MISS_W-1:0]         miss_n;
  logic [PW-1:0]             presc;
  logic [TW-1:0]             tcnt;
  logic                      tick, restart, timer_clr, last, miss_ev, level_ev, win_ev;
  logic [NOTE_W-1:0]         cur_note, note_sel, led_n;
  logic [NOTE_W-1:0]         cur_arr [DEPTH];
  logic [NOTE_W-1:0]         nxt_arr [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_unpack
    assign cur_arr[g] = seq[g*NOTE_W +: NOTE_W];
    assign nxt_arr[g] = seq_n[g*NOTE_W +: NOTE_W];
  end

  always_comb begin
    cur_note = '0;
    for (int k = 0; k < DEPTH; k++)
      if (idx == LW'(k)) cur_note = cur_arr[k];
  end

  assign tick = (presc == PW'(TICK_DIV - 1));
  assign last = ((idx + 1'b1) == len);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_n  = state;
    seq_n    = seq;
    idx_n    = idx;
    len_n    = len;
    miss_n   = miss_count;
    restart  = 1'b0;
    miss_ev  = 1'b0;
    level_ev = 1'b0;
    win_ev   = 1'b0;
    if (abort) begin
      state_n = IDLE;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE, WIN: if (load_valid) begin
          seq_n   = load_data;
          len_n   = LW'(START_LEN);
          idx_n   = '0;
          miss_n  = '0;
          state_n = PLAY_ON;
        end
        PLAY_ON: if (tick && tcnt == TW'(NOTE_TICKS - 1)) state_n = PLAY_GAP;
        PLAY_GAP: if (tick && tcnt == TW'(GAP_TICKS - 1)) begin
          idx_n   = last ? '0 : idx + 1'b1;
          state_n = last ? LISTEN : PLAY_ON;
        end
        LISTEN: begin
          // An answer outranks a timeout tick landing in the same cycle.
          if (answer_valid) begin
            if (answer != cur_note) begin
              miss_ev = 1'b1;
            end else if (!last) begin
              idx_n   = idx + 1'b1;
              restart = 1'b1;
            end else if (len < LW'(DEPTH)) begin
              len_n    = len + 1'b1;
              idx_n    = '0;
              level_ev = 1'b1;
              state_n  = PLAY_ON;
            end else begin
              win_ev  = 1'b1;
              state_n = WIN;
            end
          end else if (tick && tcnt == TW'(TIMEOUT_TICKS - 1)) begin
            miss_ev = 1'b1;
          end
          if (miss_ev) begin
            miss_n  = (&miss_count) ? miss_count : miss_count + 1'b1;
            idx_n   = '0;
            state_n = MISS;
          end
        end
        MISS: if (tick && tcnt == TW'(MISS_TICKS - 1)) begin
          idx_n   = '0;
          state_n = PLAY_ON;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign timer_clr = (state_n != state) || restart;

  always_comb begin
    note_sel = '0;
    for (int k = 0; k < DEPTH; k++)
      if (idx_n == LW'(k)) note_sel = nxt_arr[k];
  end

  // Outputs are computed from the next state so they change in the same cycle as state_out.
  always_comb begin
    led_n = '0;
    case (state_n)
      PLAY_ON: led_n = note_sel;
      LISTEN:  led_n = (state == LISTEN) ? (answer_valid ? answer : led_out) : '0;
      WIN:     led_n = '1;
      default: led_n = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      len         <= LW'(START_LEN);
      miss_count  <= '0;
      presc       <= '0;
      tcnt        <= '0;
      note_out    <= '0;
      note_active <= 1'b0;
      led_out     <= '0;
      load_ready  <= 1'b1;
      miss_pulse  <= 1'b0;
      level_pulse <= 1'b0;
      win_pulse   <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      len         <= len_n;
      miss_count  <= miss_n;
      note_out    <= (state_n == PLAY_ON) ? note_sel : '0;
      note_active <= (state_n == PLAY_ON);
      led_out     <= led_n;
      load_ready  <= (state_n == IDLE) || (state_n == WIN);
      miss_pulse  <= miss_ev;
      level_pulse <= level_ev;
      win_pulse   <= win_ev;
      if (timer_clr) begin
        presc <= '0;
        tcnt  <= '0;
      end else if (tick) begin
        presc <= '0;
        tcnt  <= tcnt + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // NOTE: the sequence store is pure data, only read after a load writes it, so it carries no reset.
  always_ff @(posedge clk) seq <= seq_n;

  assign state_out = state;
  assign level_out = len;

endmodule

// File: tb/tb_seq_game_engine.sv
// Scoreboard bench for seq_game_engine: stimulus pushes expected output segments (state run with
// its outputs, duration and pulse counts); a monitor closes each segment on a state change and compares.
module tb_seq_game_engine;
  localparam int NOTE_W = 4, DEPTH = 4, START_LEN = 2, TICK_DIV = 4, NOTE_TICKS = 2;
  localparam int GAP_TICKS = 1, MISS_TICKS = 2, TIMEOUT_TICKS = 8, MISS_W = 8;
  localparam int LW = $clog2(DEPTH + 1);

  logic                     clk, reset, load_valid, load_ready, answer_valid, abort;
  logic [NOTE_W*DEPTH-1:0]  load_data;
  logic [NOTE_W-1:0]        answer, note_out, led_out;
  logic                     note_active, miss_pulse, level_pulse, win_pulse;
  logic [2:0]               state_out;
  logic [LW-1:0]            level_out;
  logic [MISS_W-1:0]        miss_count;

  seq_game_engine #(
    .NOTE_W(NOTE_W), .DEPTH(DEPTH), .START_LEN(START_LEN), .TICK_DIV(TICK_DIV),
    .NOTE_TICKS(NOTE_TICKS), .GAP_TICKS(GAP_TICKS), .MISS_TICKS(MISS_TICKS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS), .MISS_W(MISS_W)
  ) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .answer_valid(answer_valid), .answer(answer), .abort(abort),
    .note_out(note_out), .note_active(note_active), .led_out(led_out), .state_out(state_out),
    .level_out(level_out), .miss_count(miss_count), .miss_pulse(miss_pulse),
    .level_pulse(level_pulse), .win_pulse(win_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st; int note; int na; int led; int lvl; int miss; int dur; int mp; int lp; int wp;
  } seg_t;

  seg_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   notes[4] = '{1, 2, 3, 4};
  bit   mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_seg(input int st, input int note, input int na, input int led, input int lvl,
                          input int miss, input int dur, input int mp, input int lp, input int wp);
    seg_t s;
    s.st = st; s.note = note; s.na = na; s.led = led; s.lvl = lvl;
    s.miss = miss; s.dur = dur; s.mp = mp; s.lp = lp; s.wp = wp;
    exp_q.push_back(s);
  endtask

  // Playback of notes 0..lvl-1: each note 8 cycles sounding, then 4 silent cycles.
  task automatic push_round(input int lvl, input int miss, input int lp);
    for (int i = 0; i < lvl; i++) begin
      push_seg(1, notes[i], 1, notes[i], lvl, miss, 8, 0, (i == 0) ? lp : 0, 0);
      push_seg(2, 0, 0, 0, lvl, miss, 4, 0, 0, 0);
    end
  endtask

  // Monitor: one segment per run of constant state_out, sampled on the falling edge.
  initial begin
    bit   started = 1'b0;
    int   cur_st = 0, dur = 0, mp = 0, lp = 0, wp = 0, seg_no = 0;
    int   l_note = 0, l_na = 0, l_led = 0, l_lvl = 0, l_miss = 0;
    seg_t e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        started = 1'b0;
      end else begin
        if (started && int'(state_out) != cur_st) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL seg%0d unexpected: state %0d, expected no further segment", seg_no, cur_st);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("seg%0d_state", seg_no), cur_st, e.st);
            check($sformatf("seg%0d_note", seg_no), l_note, e.note);
            check($sformatf("seg%0d_note_active", seg_no), l_na, e.na);
            check($sformatf("seg%0d_led", seg_no), l_led, e.led);
            check($sformatf("seg%0d_level", seg_no), l_lvl, e.lvl);
            check($sformatf("seg%0d_miss_count", seg_no), l_miss, e.miss);
            if (e.dur >= 0) check($sformatf("seg%0d_cycles", seg_no), dur, e.dur);
            check($sformatf("seg%0d_miss_pulses", seg_no), mp, e.mp);
            check($sformatf("seg%0d_level_pulses", seg_no), lp, e.lp);
            check($sformatf("seg%0d_win_pulses", seg_no), wp, e.wp);
          end
          seg_no++;
        end
        if (!started || int'(state_out) != cur_st) begin
          cur_st = state_out; dur = 0; mp = 0; lp = 0; wp = 0; started = 1'b1;
        end
        dur++;
        mp += miss_pulse; lp += level_pulse; wp += win_pulse;
        l_note = note_out; l_na = note_active; l_led = led_out; l_lvl = level_out; l_miss = miss_count;
      end
    end
  end

  task automatic do_load(input logic [15:0] d);
    load_data = d; load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic do_answer(input int a);
    answer = 4'(a); answer_valid = 1'b1;
    @(posedge clk); #1;
    answer_valid = 1'b0;
  endtask

  task automatic wait_state(input int s);
    int k = 0;
    while (int'(state_out) != s && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    if (int'(state_out) != s) check("wait_state_timeout", state_out, s);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, state %0d", state_out);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = '0; answer_valid = 1'b0; answer = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state_out, 0);
    check("rst_note", note_out, 0);
    check("rst_note_active", note_active, 0);
    check("rst_led", led_out, 0);
    check("rst_level", level_out, 2);
    check("rst_miss_count", miss_count, 0);
    check("rst_pulses", {miss_pulse, level_pulse, win_pulse}, 0);
    check("rst_load_ready", load_ready, 1);
    reset = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Load and first playback of notes 1,2, then timeout in LISTEN (32 cycles).
    push_seg(0, 0, 0, 0, 2, 0, -1, 0, 0, 0);
    push_round(2, 0, 0);
    do_load(16'h4321);
    wait_state(3);
    push_seg(3, 0, 0, 0, 2, 0, 32, 0, 0, 0);
    push_seg(4, 0, 0, 0, 2, 1, 8, 1, 0, 0);
    push_round(2, 1, 0);
    check("listen_load_ready", load_ready, 0);
    do_load(16'hFFFF);
    wait_state(1);
    do_answer(9);
    wait_state(3);

    // Wrong second answer: miss, replay of same round.
    push_seg(3, 0, 0, 1, 2, 1, -1, 0, 0, 0);
    push_seg(4, 0, 0, 0, 2, 2, 8, 1, 0, 0);
    push_round(2, 2, 0);
    do_answer(1);
    do_answer(5);
    check("miss_state", state_out, 4);
    check("miss_pulse_high", miss_pulse, 1);
    check("miss_count_after", miss_count, 2);
    wait_state(3);

    // Correct rounds: len 2 -> 3 -> 4.
    push_seg(3, 0, 0, 1, 2, 2, -1, 0, 0, 0);
    push_round(3, 2, 1);
    do_answer(1);
    do_answer(2);
    check("level_after_round2", level_out, 3);
    check("level_pulse_high", level_pulse, 1);
    wait_state(3);
    push_seg(3, 0, 0, 2, 3, 2, -1, 0, 0, 0);
    push_round(4, 2, 1);
    for (int i = 1; i <= 3; i++) do_answer(i);
    check("level_after_round3", level_out, 4);
    wait_state(3);

    // Full-length round wins; WIN holds, then a new load restarts.
    push_seg(3, 0, 0, 3, 4, 2, -1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) do_answer(i);
    check("win_state", state_out, 5);
    check("win_led", led_out, 15);
    check("win_load_ready", load_ready, 1);
    check("win_pulse_high", win_pulse, 1);
    @(posedge clk); #1;
    check("win_pulse_low", win_pulse, 0);
    check("win_hold", state_out, 5);
    push_seg(5, 0, 0, 15, 4, 2, -1, 0, 0, 1);
    push_round(2, 0, 0);
    do_load(16'h4321);
    check("reload_level", level_out, 2);
    check("reload_miss_count", miss_count, 0);
    wait_state(3);

    // Abort together with a round-completing answer.
    push_seg(3, 0, 0, 1, 2, 0, -1, 0, 0, 0);
    push_seg(0, 0, 0, 0, 2, 0, -1, 0, 0, 0);
    do_answer(1);
    answer = 4'd2; answer_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    answer_valid = 1'b0; abort = 1'b0;
    check("abort_state", state_out, 0);
    check("abort_led", led_out, 0);
    check("abort_level", level_out, 2);
    check("abort_no_level_pulse", level_pulse, 0);
    repeat (2) @(posedge clk);
    #1;
    do_load(16'h4321);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of PLAY_ON.
    mon_en = 1'b0;
    check("pre_reset_note", note_out, 1);
    reset = 1'b1;
    #1;
    check("async_rst_note", note_out, 0);
    check("async_rst_note_active", note_active, 0);
    check("async_rst_state", state_out, 0);
    check("async_rst_level", level_out, 2);
    check("async_rst_miss_count", miss_count, 0);
    #20;
    reset = 1'b0;
    @(posedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_game_engine.md
Name: seq_game_engine

Overview:
Parameterised note-sequence memory game engine. It loads a sequence of DEPTH notes, plays the first `len` notes on the piezo/LED outputs with exact tick timing, then checks player answers note-by-note. Each correct round grows `len` by one; a miss or timeout replays the round. The block sits between the keypad/answer decoder and the piezo tone generator and LED driver, and adds per-answer timeout, miss counting, win detection and abort, none of which the previous fixed 8-note engine had.

Parameters:
NOTE_W, 4, bits per note code (0 = silence)
DEPTH, 8, maximum sequence length (number of notes in load_data)
START_LEN, 3, notes played in the first round (1..DEPTH)
TICK_DIV, 5000000, clk cycles per tick
NOTE_TICKS, 3, ticks a note is sounded during playback
GAP_TICKS, 1, silent ticks after each played note
MISS_TICKS, 2, silent ticks after a miss before replay
TIMEOUT_TICKS, 10, ticks without an answer in LISTEN before a miss is declared
MISS_W, 8, width of the miss counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
load_valid  in  1  load request; accepted only when load_ready=1
load_ready  out  1  high in IDLE and WIN
load_data  in  NOTE_W*DEPTH  note i at bits [i*NOTE_W +: NOTE_W]; note 0 is played first
answer_valid  in  1  single-cycle answer strobe
answer  in  NOTE_W  player note code
abort  in  1  synchronous return to IDLE
note_out  out  NOTE_W  note to tone generator; 0 = silent
note_active  out  1  high while note_out is sounding
led_out  out  NOTE_W  LED pattern
state_out  out  3  IDLE=0, PLAY_ON=1, PLAY_GAP=2, LISTEN=3, MISS=4, WIN=5
level_out  out  $clog2(DEPTH+1)  current round length `len`
miss_count  out  MISS_W  saturating miss total since load
miss_pulse  out  1  one-cycle pulse on each miss
level_pulse  out  1  one-cycle pulse on each round completion that increases `len`
win_pulse  out  1  one-cycle pulse on entry to WIN

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, note_out=0, note_active=0, led_out=0, level_out=START_LEN, miss_count=0, all pulses 0, idx=0. The tick prescaler and tick counter are also cleared.
- Tick timing:
  - The prescaler counts 0..TICK_DIV-1 and emits a tick on its last count.
  - The prescaler and tick counter clear on every state transition.
  - A state lasting N ticks therefore occupies exactly N*TICK_DIV cycles, measured from the cycle state_out changes.
- IDLE / WIN:
  - load_valid=1 latches load_data, sets len=START_LEN, idx=0, miss_count=0, and moves to PLAY_ON on the next cycle.
  - load_valid is ignored in every other state.
- PLAY_ON:
  - note_out = led_out = seq[idx], note_active=1.
  - After NOTE_TICKS ticks, go to PLAY_GAP.
- PLAY_GAP:
  - note_out=0, note_active=0, led_out=0.
  - After GAP_TICKS ticks: if idx==len-1, set idx=0 and go to LISTEN; otherwise idx+1 and go to PLAY_ON.
- LISTEN:
  - note_out=0, note_active=0.
  - On answer_valid, led_out=answer.
  - Correct answer, idx<len-1: idx+1, timeout restarts, stay in LISTEN.
  - Correct answer, idx==len-1, len<DEPTH: len+1, idx=0, level_pulse, go to PLAY_ON.
  - Correct answer, idx==len-1, len==DEPTH: win_pulse, go to WIN.
  - Mismatch: miss_pulse, miss_count+1 (saturating at all-ones), idx=0, len unchanged, go to MISS.
  - TIMEOUT_TICKS ticks with no answer_valid: handled exactly as a mismatch.
- MISS:
  - All outputs silent, led_out=0.
  - After MISS_TICKS ticks, go to PLAY_ON with idx=0 (replay the same round).
- WIN:
  - note_out=0, note_active=0, led_out all ones.
  - Hold until load_valid or abort.
- Input handling:
  - answer_valid outside LISTEN is ignored: no miss, no led update.
- Abort:
  - Takes priority over every event in the same cycle.
  - Next state is IDLE with note_out=0, note_active=0, led_out=0, idx=0.
  - len and miss_count are retained.
- Simultaneous events:
  - abort > load_valid > answer_valid > tick.
  - An answer in the same cycle as the timeout tick is evaluated; the timeout is discarded.
- Widths:
  - idx and len are $clog2(DEPTH+1) bits.
  - Note select is seq[idx*NOTE_W +: NOTE_W].
  - No arithmetic overflow is possible, because len never exceeds DEPTH.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous).

Test Plan:
Bench parameters: TICK_DIV=4, NOTE_TICKS=2, GAP_TICKS=1, DEPTH=4, START_LEN=2, MISS_TICKS=2, TIMEOUT_TICKS=8, NOTE_W=4.

1. Load 0x4321 in IDLE -> note_out=1 for exactly 8 cycles, silent 4 cycles, note_out=2 for 8 cycles, silent 4 cycles, then state_out=3.
2. In LISTEN answer 1 then 2 -> level_pulse once, level_out=3, playback of 1,2,3 follows; then answer 1,2,3 -> level_out=4.
3. In round len=2 answer 1 then 5 -> miss_pulse for 1 cycle, miss_count=1, 8 silent cycles in MISS, replay 1,2, level_out stays 2.
4. In LISTEN give no answer -> miss_pulse after exactly 32 cycles; answer_valid pulsed during PLAY_ON -> no miss, led_out unchanged.
5. Complete round len=4 with 1,2,3,4 -> win_pulse, state_out=5, led_out=0xF, load_ready=1; a new load restarts with level_out=2 and miss_count=0.
6. Assert abort together with a correct answer in LISTEN -> state_out=0, no level_pulse. Assert reset mid PLAY_ON -> note_out=0, level_out=2, miss_count=0 immediately.
